// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and vote helper for the UART receive path.
package uart_pkg;

  localparam int unsigned DEF_CLK_DIV   = 48;
  localparam int unsigned DEF_OS_RATE   = 9;
  localparam int unsigned DEF_DATA_BITS = 8;

  // Vote sample indices around mid-bit for the default oversample rate
  localparam int unsigned DEF_VOTE_LO  = DEF_OS_RATE / 2 - 1;
  localparam int unsigned DEF_VOTE_MID = DEF_OS_RATE / 2;
  localparam int unsigned DEF_VOTE_HI  = DEF_OS_RATE / 2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample clock-enable generator: one-cycle tick every CLK_DIV cycles, re-phased by clr.
module uart_os_tick #(
  parameter int unsigned CLK_DIV = 48
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             at_top;

  assign at_top = (cnt == CNT_W'(CLK_DIV - 1));
  // A clear suppresses the tick so the first tick lands CLK_DIV cycles later
  assign tick_c = at_top & ~clr;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || at_top) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 9x oversampled, 3-sample majority vote, valid/ready holding register.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned OS_RATE   = DEF_OS_RATE,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk_50mhz,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int unsigned SAMP_W  = $clog2(OS_RATE);
  localparam int unsigned BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned VOTE_LO  = OS_RATE / 2 - 1;
  localparam int unsigned VOTE_MID = OS_RATE / 2;
  localparam int unsigned VOTE_HI  = OS_RATE / 2 + 1;

  rx_state_t state, state_nxt;

  logic                 rxd_meta, rxd_sync, rxd_prev;
  logic                 start_edge_c;
  logic                 os_tick;
  logic [SAMP_W-1:0]    samp_cnt;
  logic [2:0]           vote;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_end_c, stop_pt_c;
  logic                 vote_bit_c, stop_vote_c;

  logic tick_clr, bit_clr, bit_shift, deliver, ferr_set;

  // Two-flop synchronizer plus one history flop for falling-edge detect
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign start_edge_c = rxd_prev & ~rxd_sync;

  uart_os_tick #(.CLK_DIV(CLK_DIV)) u_os_tick (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .clr       (tick_clr),
    .tick_c    (os_tick)
  );

  assign bit_end_c   = os_tick && (samp_cnt == SAMP_W'(OS_RATE - 1));
  assign stop_pt_c   = os_tick && (samp_cnt == SAMP_W'(VOTE_HI));
  assign vote_bit_c  = maj3(vote);
  // Stop decision happens on the last vote sample, so fold in the live sample
  assign stop_vote_c = maj3({rxd_sync, vote[1:0]});

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick_clr  = 1'b0;
    bit_clr   = 1'b0;
    bit_shift = 1'b0;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_edge_c) begin
          tick_clr  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          if (vote_bit_c) begin
            state_nxt = ST_IDLE;
          end else begin
            bit_clr   = 1'b1;
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          bit_shift = 1'b1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (stop_pt_c) begin
          if (stop_vote_c) begin
            deliver   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_sync) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sample position, vote capture, bit count and shift register
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt  <= '0;
      vote      <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (tick_clr) begin
        samp_cnt <= '0;
      end else if (os_tick) begin
        samp_cnt <= bit_end_c ? '0 : samp_cnt + SAMP_W'(1);
        if (samp_cnt == SAMP_W'(VOTE_LO))  vote[0] <= rxd_sync;
        if (samp_cnt == SAMP_W'(VOTE_MID)) vote[1] <= rxd_sync;
        if (samp_cnt == SAMP_W'(VOTE_HI))  vote[2] <= rxd_sync;
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (bit_shift) begin
        bit_cnt   <= bit_cnt + BIT_W'(1);
        shift_reg <= {vote_bit_c, shift_reg[DATA_BITS-1:1]};
      end
    end
  end

  // Host-side holding register and status pulses
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= deliver && rx_valid && !rx_ready;
      rx_busy   <= (state_nxt != ST_IDLE);
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: expected bytes queued at stimulus time, checked by a monitor.
module tb_uart_rx_ctrl;

  localparam int unsigned BIT_CYC = 432;

  logic       clk_50mhz;
  logic       rst_n;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt = 0, ov_cnt = 0, valid_cnt = 0;
  int fe0, ov0, v0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data  = '0;

  uart_rx_ctrl dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  initial begin
    clk_50mhz = 1'b0;
    forever #10 clk_50mhz = ~clk_50mhz;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  // One 8N1 frame; flip_bit >= 0 inverts only that bit's middle vote sample
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int flip_bit);
    rxd = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      if (i == flip_bit) begin
        cyc(230);
        rxd = ~d[i];
        cyc(20);
        rxd = d[i];
        cyc(182);
      end else begin
        cyc(BIT_CYC);
      end
    end
    rxd = stop_v;
    cyc(BIT_CYC);
  endtask

  // Monitor: samples just after the falling edge, pops on each accepted byte
  always @(negedge clk_50mhz) begin
    #1;
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (rx_valid)  valid_cnt++;
      if (prev_valid && !prev_ready && rx_valid)
        check("data_hold", 32'(rx_data), 32'(prev_data));
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_byte: got 0x%0h, expected no byte", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_valid = rx_valid & rst_n;
    prev_ready = rx_ready;
    prev_data  = rx_data;
  end

  task automatic snap();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    v0  = valid_cnt;
  endtask

  initial begin
    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    cyc(5);
    #2;
    check("rst_rx_valid",  32'(rx_valid),  32'd0);
    check("rst_rx_data",   32'(rx_data),   32'd0);
    check("rst_rx_busy",   32'(rx_busy),   32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(20);

    // Clean frame, host always ready
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    cyc(10);
    #2;
    check("a5_valid_cycles", 32'(valid_cnt - v0), 32'd1);
    check("a5_frame_err",    32'(fe_cnt - fe0),   32'd0);
    check("a5_overrun",      32'(ov_cnt - ov0),   32'd0);
    check("a5_busy_after",   32'(rx_busy),        32'd0);
    check("a5_q_empty",      32'(exp_q.size()),   32'd0);

    // Glitch shorter than a bit: false start, busy only through the start bit
    snap();
    rxd = 1'b0;
    cyc(100);
    rxd = 1'b1;
    cyc(320);
    #2;
    check("fs_busy_in_start", 32'(rx_busy), 32'd1);
    cyc(30);
    #2;
    check("fs_busy_after",   32'(rx_busy),        32'd0);
    check("fs_no_valid",     32'(valid_cnt - v0), 32'd0);
    check("fs_no_frame_err", 32'(fe_cnt - fe0),   32'd0);
    cyc(500);

    // Stop bit low then line held in break
    snap();
    send_frame(8'h55, 1'b0, -1);
    cyc(2000);
    #2;
    check("brk_frame_err_pulses", 32'(fe_cnt - fe0),   32'd1);
    check("brk_no_valid",         32'(valid_cnt - v0), 32'd0);
    check("brk_busy_held",        32'(rx_busy),        32'd1);
    cyc(1);
    rxd = 1'b1;
    cyc(10);
    #2;
    check("brk_busy_released", 32'(rx_busy), 32'd0);
    cyc(50);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, -1);
    cyc(10);
    #2;
    check("brk_next_q_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames with host stalled: second byte overruns
    cyc(1);
    snap();
    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    cyc(10);
    #2;
    check("ovr_pulses",   32'(ov_cnt - ov0), 32'd1);
    check("ovr_valid",    32'(rx_valid),     32'd1);
    check("ovr_data",     32'(rx_data),      32'h3C);
    check("ovr_no_ferr",  32'(fe_cnt - fe0), 32'd0);
    cyc(1);
    rx_ready = 1'b1;
    cyc(1);
    #2;
    check("ovr_valid_drop", 32'(rx_valid),     32'd0);
    check("ovr_q_empty",    32'(exp_q.size()), 32'd0);
    cyc(20);

    // Reset in the middle of data bit 4 aborts the frame
    fork
      send_frame(8'hF0, 1'b1, -1);
      begin
        cyc(BIT_CYC * 5 + 216);
        #2;
        check("mid_busy_pre_rst", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(rx_busy),   32'd0);
        check("mid_rst_valid", 32'(rx_valid),  32'd0);
        check("mid_rst_data",  32'(rx_data),   32'd0);
        check("mid_rst_ferr",  32'(frame_err), 32'd0);
        check("mid_rst_ovr",   32'(overrun),   32'd0);
      end
    join
    cyc(20);
    rst_n = 1'b1;
    cyc(20);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    cyc(10);
    #2;
    check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);
    check("post_rst_busy",    32'(rx_busy),      32'd0);

    // One corrupted middle sample on data bit 2 is outvoted
    cyc(1);
    snap();
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 2);
    cyc(10);
    #2;
    check("vote_q_empty",  32'(exp_q.size()),   32'd0);
    check("vote_no_ferr",  32'(fe_cnt - fe0),   32'd0);
    check("vote_one_byte", 32'(valid_cnt - v0), 32'd1);

    cyc(50);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
